// File: rtl/tetris_pkg.sv
// tetris_pkg: types and constants shared by the Tetris playfield logic.
//   block_color  : 3-bit cell colour, EMPTY = 0 marks a free cell.
//   clr_state_e  : line-clear engine states.
//   PLAY_COLS / PLAY_ROWS / CELL_PX : playfield geometry.
//   CNT_W / sat_inc : cleared-row counter width and saturating increment.
package tetris_pkg;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    CYAN   = 3'd1,
    YELLOW = 3'd2,
    PURPLE = 3'd3,
    GREEN  = 3'd4,
    RED    = 3'd5,
    BLUE   = 3'd6,
    ORANGE = 3'd7
  } block_color;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SCAN  = 2'd1,
    CLR_SHIFT = 2'd2,
    CLR_DONE  = 2'd3
  } clr_state_e;

  localparam int PLAY_COLS = 10;
  localparam int PLAY_ROWS = 20;
  localparam int CELL_PX   = 20;
  localparam int CNT_W     = 5;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: sequencing for the line-clear engine.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_clear_start    : request a clear (honoured only in IDLE)
//   i_row_full       : one bit per row, set when every cell of the row is filled
//   o_state          : current FSM state (debug visibility)
//   o_shift_en       : move one row down this cycle
//   o_shift_row      : destination row of the move
//   o_clear_row0     : with o_shift_en, blank row 0 instead of copying
//   o_busy           : SCAN or SHIFT
//   o_done           : one-cycle completion pulse
//   o_cnt            : rows removed so far in this clear
// Scanning runs bottom to top. After a full row is removed the same row index
// is scanned again, because the row above has just dropped into it.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS = PLAY_ROWS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear_start,
  input  logic [ROWS-1:0]  i_row_full,
  output clr_state_e       o_state,
  output logic             o_shift_en,
  output logic [4:0]       o_shift_row,
  output logic             o_clear_row0,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  clr_state_e       r_state, w_state_nxt;
  logic [4:0]       r_row,   w_row_nxt;
  logic [4:0]       r_srow,  w_srow_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CLR_IDLE;
      r_row   <= '0;
      r_srow  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_srow  <= w_srow_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_srow_nxt   = r_srow;
    w_cnt_nxt    = r_cnt;
    o_shift_en   = 1'b0;
    o_clear_row0 = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      CLR_IDLE: begin
        if (i_clear_start) begin
          w_state_nxt = CLR_SCAN;
          w_row_nxt   = LAST_ROW;
          w_cnt_nxt   = '0;
        end
      end
      CLR_SCAN: begin
        o_busy = 1'b1;
        if (i_row_full[r_row]) begin
          w_cnt_nxt   = sat_inc(r_cnt);
          w_srow_nxt  = r_row;
          w_state_nxt = CLR_SHIFT;
        end else if (r_row == 5'd0) begin
          w_state_nxt = CLR_DONE;
        end else begin
          w_row_nxt = r_row - 5'd1;
        end
      end
      CLR_SHIFT: begin
        o_busy     = 1'b1;
        o_shift_en = 1'b1;
        if (r_srow == 5'd0) begin
          // Top row has nothing above it to inherit: it becomes empty.
          o_clear_row0 = 1'b1;
          w_state_nxt  = CLR_SCAN;
        end else begin
          w_srow_nxt = r_srow - 5'd1;
        end
      end
      CLR_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = CLR_IDLE;
      end
      default: w_state_nxt = CLR_IDLE;
    endcase
  end

  assign o_state     = r_state;
  assign o_shift_row = r_srow;
  assign o_cnt       = r_cnt;

endmodule

// File: rtl/board_store.sv
// board_store: Tetris playfield storage plus line-clear engine.
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   rd_x, rd_y          : renderer address; rd_color is the cell one cycle later
//                         (EMPTY when off the board)
//   q_x, q_y            : collision query; q_occupied is combinational and
//                         reports 1 off the board so walls and floor are solid
//   wr_en/wr_x/wr_y/wr_color : cell write, taken only while the engine is idle
//   clear_start         : start a line clear
//   busy, done          : engine scanning/shifting; completion pulse
//   lines_cleared       : rows removed by the last completed clear
// Cells live in flops so a whole row can move down in a single cycle.
module board_store
  import tetris_pkg::*;
#(
  parameter int COLS = PLAY_COLS,
  parameter int ROWS = PLAY_ROWS
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [4:0] rd_x,
  input  logic [4:0] rd_y,
  output block_color rd_color,
  input  logic [4:0] q_x,
  input  logic [4:0] q_y,
  output logic       q_occupied,
  input  logic       wr_en,
  input  logic [4:0] wr_x,
  input  logic [4:0] wr_y,
  input  block_color wr_color,
  input  logic       clear_start,
  output logic       busy,
  output logic       done,
  output logic [4:0] lines_cleared
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  block_color       r_cells [ROWS][COLS];
  block_color       r_rd_color;
  logic [4:0]       r_lines_cleared;

  logic [ROWS-1:0]  w_row_full;
  clr_state_e       w_state;
  logic             w_shift_en;
  logic [4:0]       w_shift_row;
  logic             w_clear_row0;
  logic             w_busy;
  logic             w_done;
  logic [CNT_W-1:0] w_cnt;
  logic             w_rd_in;
  logic             w_q_in;
  logic             w_wr_ok;

  always_comb begin
    w_row_full = '1;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        if (r_cells[y][x] == EMPTY) w_row_full[y] = 1'b0;
      end
    end
  end

  line_clear_ctrl #(.ROWS(ROWS)) u_ctrl (
    .i_clk         (Clk),
    .i_rst_n       (Reset_n),
    .i_clear_start (clear_start),
    .i_row_full    (w_row_full),
    .o_state       (w_state),
    .o_shift_en    (w_shift_en),
    .o_shift_row   (w_shift_row),
    .o_clear_row0  (w_clear_row0),
    .o_busy        (w_busy),
    .o_done        (w_done),
    .o_cnt         (w_cnt)
  );

  assign w_rd_in = (rd_x < 5'(COLS)) && (rd_y < 5'(ROWS));
  assign w_q_in  = (q_x  < 5'(COLS)) && (q_y  < 5'(ROWS));
  // A write in the same cycle as clear_start still lands, since the engine
  // is idle at that edge; the scan then sees it.
  assign w_wr_ok = wr_en && (w_state == CLR_IDLE) &&
                   (wr_x < 5'(COLS)) && (wr_y < 5'(ROWS));

  assign q_occupied = !w_q_in || (r_cells[q_y[RW-1:0]][q_x[CW-1:0]] != EMPTY);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int y = 0; y < ROWS; y++) begin
        for (int x = 0; x < COLS; x++) begin
          r_cells[y][x] <= EMPTY;
        end
      end
    end else if (w_shift_en) begin
      if (w_clear_row0) begin
        for (int x = 0; x < COLS; x++) r_cells[0][x] <= EMPTY;
      end else begin
        for (int x = 0; x < COLS; x++) begin
          r_cells[w_shift_row][x] <= r_cells[w_shift_row - 5'd1][x];
        end
      end
    end else if (w_wr_ok) begin
      r_cells[wr_y[RW-1:0]][wr_x[CW-1:0]] <= wr_color;
    end
  end

  // Reads are never blocked; mid-shift they return in-flight contents.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd_color <= EMPTY;
    end else begin
      r_rd_color <= w_rd_in ? r_cells[rd_y[RW-1:0]][rd_x[CW-1:0]] : EMPTY;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_lines_cleared <= '0;
    end else if (w_done) begin
      r_lines_cleared <= w_cnt;
    end
  end

  assign rd_color      = r_rd_color;
  assign busy          = w_busy;
  assign done          = w_done;
  assign lines_cleared = r_lines_cleared;

endmodule
